// File: rtl/uart_cmd_pkg.sv
// Shared command codes, ALU function encoding, controller states and ALU helper.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_RF_WR   = 8'hAA;
    localparam logic [7:0] CMD_RF_RD   = 8'hBB;
    localparam logic [7:0] CMD_ALU_OP  = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOP = 8'hDD;

    typedef enum logic [3:0] {
        FUN_ADD = 4'd0,  FUN_SUB = 4'd1,  FUN_NOT = 4'd2,  FUN_AND = 4'd3,
        FUN_OR  = 4'd4,  FUN_XOR = 4'd5,  FUN_MUL = 4'd6,  FUN_DIV = 4'd7,
        FUN_EQ  = 4'd8,  FUN_GT  = 4'd9,  FUN_SHR = 4'd10, FUN_SHL = 4'd11
    } alu_fun_t;

    typedef enum logic [2:0] {
        IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, NOP_FUN
    } ctrl_state_t;

    // 16-bit ALU result; 8-bit operations are zero-extended.
    function automatic logic [15:0] alu_calc(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] fun);
        logic [15:0] wa;
        logic [15:0] wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (alu_fun_t'(fun))
            FUN_ADD: alu_calc = wa + wb;
            FUN_SUB: alu_calc = wa - wb;
            FUN_NOT: alu_calc = {8'h00, ~a};
            FUN_AND: alu_calc = wa & wb;
            FUN_OR:  alu_calc = wa | wb;
            FUN_XOR: alu_calc = wa ^ wb;
            FUN_MUL: alu_calc = wa * wb;
            FUN_DIV: alu_calc = (b == 8'h00) ? 16'hFFFF : {8'h00, a / b};
            FUN_EQ:  alu_calc = (a == b) ? 16'h0001 : 16'h0000;
            FUN_GT:  alu_calc = (a > b) ? 16'h0001 : 16'h0000;
            FUN_SHR: alu_calc = wa >> 1;
            FUN_SHL: alu_calc = wa << 1;
            default: alu_calc = '0;
        endcase
    endfunction

endpackage

// File: rtl/uart_cmd_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampler, even-parity and stop checks.
module uart_cmd_rx #(
    parameter int unsigned BIT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    output logic       parity_error,
    output logic       framing_error
);

    localparam int unsigned CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(BIT_CYCLES / 2 - 1);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

    rx_state_t     state_q, state_d;
    logic [1:0]    sync_q;
    logic          rx_prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shreg_q;
    logic          par_q;
    logic          rx_s;
    logic          sample;

    assign rx_s = sync_q[1];

    // Synchronize the asynchronous line and keep the previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
        end else begin
            sync_q    <= {sync_q[0], rx_in};
            rx_prev_q <= rx_s;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    // Next state; start bit sampled at half a bit, all others at mid-bit.
    always_comb begin
        state_d = state_q;
        sample  = (state_q != RX_IDLE) &&
                  (cnt_q == ((state_q == RX_START) ? HALF_CNT : LAST_CNT));
        case (state_q)
            RX_IDLE:  if (rx_prev_q && !rx_s) state_d = RX_START;
            RX_START: if (sample) state_d = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (sample && bit_idx_q == 3'd7) state_d = RX_PAR;
            RX_PAR:   if (sample) state_d = RX_STOP;
            RX_STOP:  if (sample) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    // Bit timing, data shifting and end-of-frame status registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            bit_idx_q     <= '0;
            shreg_q       <= '0;
            par_q         <= 1'b0;
            byte_data     <= '0;
            byte_valid    <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            cnt_q      <= (state_q == RX_IDLE || sample) ? '0 : cnt_q + 1'b1;
            if (sample) begin
                case (state_q)
                    RX_START: bit_idx_q <= '0;
                    RX_DATA: begin
                        shreg_q   <= {rx_s, shreg_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                    end
                    RX_PAR:   par_q <= rx_s;
                    RX_STOP: begin
                        parity_error  <= ^shreg_q ^ par_q;
                        framing_error <= ~rx_s;
                        byte_valid    <= ~(^shreg_q ^ par_q) & rx_s;
                        byte_data     <= shreg_q;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_cmd_tx.sv
// UART transmitter: 11-bit frame shifter; ready on the last cycle allows gapless frames.
module uart_cmd_tx #(
    parameter int unsigned BIT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data,
    output logic       ready,
    output logic       tx_out
);

    localparam int unsigned CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);

    logic          busy_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    bit_idx_q;
    logic [10:0]   shreg_q;

    assign tx_out = shreg_q[0];

    // Accept a new byte when idle or in the final cycle of the stop bit.
    always_comb begin
        ready = !busy_q || (cnt_q == LAST_CNT && bit_idx_q == 4'd10);
    end

    // Shift the frame out LSB first, refilling with idle-high ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '1;
        end else if (ready && start) begin
            shreg_q   <= {1'b1, ^data, data, 1'b0};
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            bit_idx_q <= '0;
        end else if (busy_q) begin
            if (cnt_q == LAST_CNT) begin
                cnt_q   <= '0;
                shreg_q <= {1'b1, shreg_q[10:1]};
                if (bit_idx_q == 4'd10) busy_q    <= 1'b0;
                else                    bit_idx_q <= bit_idx_q + 1'b1;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_cmd_system.sv
// UART command processor: RX/TX, register file, ALU, TX byte queue and controller FSM.
module uart_cmd_system #(
    parameter int unsigned BIT_CYCLES = 32,
    parameter int unsigned RF_DEPTH   = 16,
    parameter int unsigned TXQ_DEPTH  = 4
) (
    input  logic REF_CLK,
    input  logic RST_N,
    input  logic UART_RX_IN,
    output logic UART_TX_O,
    output logic parity_error,
    output logic framing_error
);
    import uart_cmd_pkg::*;

    localparam int unsigned AW  = $clog2(RF_DEPTH);
    localparam int unsigned PW  = $clog2(TXQ_DEPTH);
    localparam int unsigned QCW = $clog2(TXQ_DEPTH + 1);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          tx_ready;
    logic [7:0]    rf [RF_DEPTH];
    logic [7:0]    q_mem [TXQ_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [QCW-1:0] q_count;
    logic          q_push, q_pop, q_full, do_push;
    logic [7:0]    q_data;

    ctrl_state_t   state_q, state_d;
    logic [AW-1:0] addr_q;
    logic          hi_pend_q;
    logic [7:0]    hi_byte_q;
    logic          addr_ld, hi_ld, rf_we, ctl_push;
    logic [AW-1:0] rf_wa;
    logic [7:0]    rf_wd, ctl_data;
    logic [15:0]   alu_res;

    uart_cmd_rx #(.BIT_CYCLES(BIT_CYCLES)) u_rx (
        .clk(REF_CLK), .rst_n(RST_N), .rx_in(UART_RX_IN),
        .byte_data(rx_byte), .byte_valid(rx_valid),
        .parity_error(parity_error), .framing_error(framing_error)
    );

    uart_cmd_tx #(.BIT_CYCLES(BIT_CYCLES)) u_tx (
        .clk(REF_CLK), .rst_n(RST_N), .start(q_pop), .data(q_mem[rd_ptr]),
        .ready(tx_ready), .tx_out(UART_TX_O)
    );

    // The ALU high byte is pushed one cycle after the low byte via a pending flag.
    always_comb begin
        q_push  = hi_pend_q | ctl_push;
        q_data  = hi_pend_q ? hi_byte_q : ctl_data;
        q_full  = (q_count == QCW'(TXQ_DEPTH));
        do_push = q_push && !q_full;
        q_pop   = tx_ready && (q_count != '0);
    end

    // Queue storage.
    always_ff @(posedge REF_CLK) begin
        if (do_push) q_mem[wr_ptr] <= q_data;
    end

    // Queue pointers and occupancy.
    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == PW'(TXQ_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (q_pop)   rd_ptr <= (rd_ptr == PW'(TXQ_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            q_count <= q_count + QCW'(do_push) - QCW'(q_pop);
        end
    end

    // Register file.
    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < RF_DEPTH; i++) rf[i] <= '0;
        end else if (rf_we) begin
            rf[rf_wa] <= rf_wd;
        end
    end

    // Controller state, latched address and pending ALU high byte.
    always_ff @(posedge REF_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            hi_pend_q <= 1'b0;
            hi_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            hi_pend_q <= hi_ld;
            if (addr_ld) addr_q    <= rx_byte[AW-1:0];
            if (hi_ld)   hi_byte_q <= alu_res[15:8];
        end
    end

    // Command decode: advances only on valid received bytes, never stalls.
    always_comb begin
        state_d  = state_q;
        addr_ld  = 1'b0;
        hi_ld    = 1'b0;
        rf_we    = 1'b0;
        rf_wa    = '0;
        rf_wd    = rx_byte;
        ctl_push = 1'b0;
        ctl_data = '0;
        alu_res  = alu_calc(rf[0], rf[1], rx_byte[3:0]);
        if (rx_valid) begin
            case (state_q)
                IDLE: begin
                    case (rx_byte)
                        CMD_RF_WR:   state_d = WR_ADDR;
                        CMD_RF_RD:   state_d = RD_ADDR;
                        CMD_ALU_OP:  state_d = ALU_A;
                        CMD_ALU_NOP: state_d = NOP_FUN;
                        default:     state_d = IDLE;
                    endcase
                end
                WR_ADDR: begin
                    addr_ld = 1'b1;
                    state_d = WR_DATA;
                end
                WR_DATA: begin
                    rf_we   = 1'b1;
                    rf_wa   = addr_q;
                    state_d = IDLE;
                end
                RD_ADDR: begin
                    ctl_push = 1'b1;
                    ctl_data = rf[rx_byte[AW-1:0]];
                    state_d  = IDLE;
                end
                ALU_A: begin
                    rf_we   = 1'b1;
                    rf_wa   = AW'(0);
                    state_d = ALU_B;
                end
                ALU_B: begin
                    rf_we   = 1'b1;
                    rf_wa   = AW'(1);
                    state_d = ALU_FUN;
                end
                ALU_FUN, NOP_FUN: begin
                    ctl_push = 1'b1;
                    ctl_data = alu_res[7:0];
                    hi_ld    = 1'b1;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_system.sv
// Directed self-checking bench for uart_cmd_system.
module tb_uart_cmd_system;

    localparam int BIT = 32;

    logic REF_CLK = 1'b0;
    logic RST_N;
    logic UART_RX_IN;
    logic UART_TX_O;
    logic parity_error;
    logic framing_error;

    int errors = 0;
    int checks = 0;
    int tx_falls = 0;
    int falls_snap;
    logic mon_en = 1'b1;
    logic [9:0] mon_fr;
    logic [9:0] rxq [$];

    uart_cmd_system #(.BIT_CYCLES(BIT), .RF_DEPTH(16), .TXQ_DEPTH(4)) dut (
        .REF_CLK(REF_CLK), .RST_N(RST_N), .UART_RX_IN(UART_RX_IN),
        .UART_TX_O(UART_TX_O), .parity_error(parity_error), .framing_error(framing_error)
    );

    always #5 REF_CLK = ~REF_CLK;

    always @(negedge UART_TX_O) tx_falls <= tx_falls + 1;

    // Serial receiver model: captures {stop, parity, data} of each TX frame.
    always begin
        @(negedge UART_TX_O);
        repeat (BIT / 2) @(negedge REF_CLK);
        if (UART_TX_O == 1'b0) begin
            for (int i = 0; i < 10; i++) begin
                repeat (BIT) @(negedge REF_CLK);
                mon_fr[i] = UART_TX_O;
            end
            if (mon_en) rxq.push_back(mon_fr);
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge REF_CLK);
    endtask

    // One frame on the RX line followed by two idle bit times.
    task automatic send(input logic [7:0] d, input logic par_flip = 1'b0,
                        input logic stop_b = 1'b1);
        logic [10:0] f;
        f = {stop_b, ^d ^ par_flip, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            UART_RX_IN = f[i];
            cycles(BIT);
        end
        UART_RX_IN = 1'b1;
        cycles(2 * BIT);
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k;
        k = 0;
        while (rxq.size() < n && k < 5000) begin
            cycles(1);
            k++;
        end
        check(tag, 16'(rxq.size() >= n), 16'd1);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] exp);
        logic [9:0] got;
        got = (rxq.size() > 0) ? rxq.pop_front() : 10'h000;
        check(tag, {6'h0, got}, {6'h0, 1'b1, ^exp, exp});
    endtask

    initial begin
        RST_N = 1'b0;
        UART_RX_IN = 1'b1;
        cycles(5);
        check("reset_tx", {15'h0, UART_TX_O}, 16'd1);
        check("reset_perr", {15'h0, parity_error}, 16'd0);
        check("reset_ferr", {15'h0, framing_error}, 16'd0);
        RST_N = 1'b1;
        cycles(20);

        // Write RF[4] = 0x55: no response expected.
        send(8'hAA); send(8'h04); send(8'h55);
        cycles(100);
        check("wr_no_tx", 16'(tx_falls), 16'd0);
        check("wr_perr", {15'h0, parity_error}, 16'd0);
        check("wr_ferr", {15'h0, framing_error}, 16'd0);

        // Read RF[4].
        send(8'hBB); send(8'h04);
        wait_frames(1, "rd_wait");
        check_frame("rd_data", 8'h55);

        // ALU ADD 0x0A + 0x05 = 0x000F.
        send(8'hCC); send(8'h0A); send(8'h05); send(8'h00);
        wait_frames(2, "add_wait");
        check_frame("add_lo", 8'h0F);
        check_frame("add_hi", 8'h00);

        // NOP command with NOT: ~0x0A = 0x00F5.
        send(8'hDD); send(8'h02);
        wait_frames(2, "not_wait");
        check_frame("not_lo", 8'hF5);
        check_frame("not_hi", 8'h00);

        // Parity error on 0xAA: flag set, byte discarded.
        send(8'hAA, 1'b1);
        check("par_perr", {15'h0, parity_error}, 16'd1);
        check("par_ferr", {15'h0, framing_error}, 16'd0);
        // Framing error on 0xBB: flag set, byte discarded.
        send(8'hBB, 1'b0, 1'b0);
        check("frm_ferr", {15'h0, framing_error}, 16'd1);
        check("frm_perr", {15'h0, parity_error}, 16'd0);
        // Valid frame clears both; controller must still be idle.
        send(8'hBB);
        check("clr_perr", {15'h0, parity_error}, 16'd0);
        check("clr_ferr", {15'h0, framing_error}, 16'd0);
        send(8'h04);
        wait_frames(1, "idle_wait");
        check_frame("idle_rd", 8'h55);

        // Short start pulse: rejected, no frame decoded.
        UART_RX_IN = 1'b0;
        cycles(BIT / 4);
        UART_RX_IN = 1'b1;
        cycles(14 * BIT);
        check("glitch_perr", {15'h0, parity_error}, 16'd0);
        check("glitch_ferr", {15'h0, framing_error}, 16'd0);

        // Address wrap: 0x14 reads RF[4].
        send(8'hBB); send(8'h14);
        wait_frames(1, "wrap_wait");
        check_frame("wrap_rd", 8'h55);

        // DIV by zero: 7 / 0 = 0xFFFF.
        send(8'hCC); send(8'h07); send(8'h00); send(8'h07);
        wait_frames(2, "div_wait");
        check_frame("div0_lo", 8'hFF);
        check_frame("div0_hi", 8'hFF);

        // ADD with carry: 0xFF + 0x02 = 0x0101.
        send(8'hCC); send(8'hFF); send(8'h02); send(8'h00);
        wait_frames(2, "carry_wait");
        check_frame("carry_lo", 8'h01);
        check_frame("carry_hi", 8'h01);

        // Reset in the middle of a TX frame with a second byte still queued.
        falls_snap = tx_falls;
        send(8'hDD); send(8'h02);
        begin
            int k;
            k = 0;
            while (tx_falls == falls_snap && k < 2000) begin
                cycles(1);
                k++;
            end
            check("rst_tx_started", 16'(tx_falls != falls_snap), 16'd1);
        end
        cycles(70);
        check("rst_tx_low", {15'h0, UART_TX_O}, 16'd0);
        mon_en = 1'b0;
        #1 RST_N = 1'b0;
        #1 check("rst_tx_async", {15'h0, UART_TX_O}, 16'd1);
        cycles(5);
        RST_N = 1'b1;
        falls_snap = tx_falls;
        cycles(1000);
        check("rst_q_empty", 16'(tx_falls - falls_snap), 16'd0);
        check("rst_line_high", {15'h0, UART_TX_O}, 16'd1);

        // Register file cleared by reset.
        rxq.delete();
        mon_en = 1'b1;
        send(8'hBB); send(8'h04);
        wait_frames(1, "post_rst_wait");
        check_frame("post_rst_rd", 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
